// File: rtl/clock_pkg.sv
// Types and constants shared by the digital-clock counter stages.
package clock_pkg;

  typedef logic [3:0] bcd_t;

  localparam int HOUR_MAX_24 = 23;
  localparam int HOUR_MAX_12 = 12;
  localparam int HOUR_MIN_12 = 1;

  localparam bcd_t RST_TENS_24 = 4'd0;
  localparam bcd_t RST_ONES_24 = 4'd0;
  localparam bcd_t RST_TENS_12 = 4'd1;
  localparam bcd_t RST_ONES_12 = 4'd2;

endpackage

// File: rtl/cnt24_hour_edge_sync.sv
// Multi-flop synchronizer with rising-edge detect, held off after reset until
// the chain has refilled so a level already high at release is not an edge.
module edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic CLR_n,
  input  logic d,
  output logic q_rise
);

  localparam int ARM_W = $clog2(SYNC_STAGES + 2);
  localparam logic [ARM_W-1:0] ARM_CNT = ARM_W'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic [ARM_W-1:0]       r_arm_cnt;
  logic                   w_armed;

  always_ff @(posedge clk or negedge CLR_n) begin
    if (!CLR_n) begin
      r_sync    <= '0;
      r_prev    <= 1'b0;
      r_arm_cnt <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], d};
      r_prev <= r_sync[SYNC_STAGES-1];
      if (r_arm_cnt != ARM_CNT) r_arm_cnt <= r_arm_cnt + ARM_W'(1);
    end
  end

  assign w_armed = (r_arm_cnt == ARM_CNT);
  assign q_rise  = r_sync[SYNC_STAGES-1] & ~r_prev & w_armed;

endmodule

// File: rtl/cnt24_hour.sv
// Hour stage: BCD hour count driven by the minute-tens carry or by manual
// set presses, with optional 12h/PM mode and a one-clock day carry.
module cnt24_hour
  import clock_pkg::*;
#(
  parameter bit MODE_12H    = 1'b0,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic CLR_n,
  input  logic bit6,
  input  logic set_inc,
  input  logic isSetting,
  output bcd_t hour_tens,
  output bcd_t hour_ones,
  output logic pm,
  output logic day_carry
);

  localparam bcd_t RST_TENS = MODE_12H ? RST_TENS_12 : RST_TENS_24;
  localparam bcd_t RST_ONES = MODE_12H ? RST_ONES_12 : RST_ONES_24;

  bcd_t       r_tens, r_ones;
  logic       r_pm, r_day_carry;
  logic       w_carry_rise, w_set_rise, w_inc, w_illegal, w_wrap, w_nxt_pm;
  bcd_t       w_nxt_tens, w_nxt_ones;
  logic [7:0] w_hour;

  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_carry_sync (
    .clk(clk), .CLR_n(CLR_n), .d(bit6), .q_rise(w_carry_rise)
  );

  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_set_sync (
    .clk(clk), .CLR_n(CLR_n), .d(set_inc), .q_rise(w_set_rise)
  );

  // The mode in the edge cycle picks the source; the other edge is dropped.
  assign w_inc  = isSetting ? w_set_rise : w_carry_rise;
  assign w_hour = {4'd0, r_tens} * 8'd10 + {4'd0, r_ones};

  always_comb begin
    w_illegal = (r_ones > 4'd9);
    if (MODE_12H)
      w_illegal = w_illegal || (w_hour > 8'(HOUR_MAX_12)) || (w_hour < 8'(HOUR_MIN_12));
    else
      w_illegal = w_illegal || (w_hour > 8'(HOUR_MAX_24));
  end

  always_comb begin
    w_nxt_tens = r_tens;
    w_nxt_ones = r_ones;
    w_nxt_pm   = r_pm;
    w_wrap     = 1'b0;
    if (MODE_12H && w_hour == 8'(HOUR_MAX_12)) begin
      w_nxt_tens = 4'd0;
      w_nxt_ones = 4'(HOUR_MIN_12);
    end else if (!MODE_12H && w_hour == 8'(HOUR_MAX_24)) begin
      w_nxt_tens = 4'd0;
      w_nxt_ones = 4'd0;
      w_wrap     = 1'b1;
    end else if (r_ones == 4'd9) begin
      w_nxt_tens = r_tens + 4'd1;
      w_nxt_ones = 4'd0;
    end else begin
      w_nxt_ones = r_ones + 4'd1;
      // 11 -> 12 flips the meridiem; leaving PM is the start of a new day.
      if (MODE_12H && w_hour == 8'd11) begin
        w_nxt_pm = ~r_pm;
        w_wrap   = r_pm;
      end
    end
  end

  always_ff @(posedge clk or negedge CLR_n) begin
    if (!CLR_n) begin
      r_tens      <= RST_TENS;
      r_ones      <= RST_ONES;
      r_pm        <= 1'b0;
      r_day_carry <= 1'b0;
    end else if (w_illegal) begin
      r_tens      <= RST_TENS;
      r_ones      <= RST_ONES;
      r_pm        <= 1'b0;
      r_day_carry <= 1'b0;
    end else begin
      r_day_carry <= w_inc & w_wrap & ~isSetting;
      if (w_inc) begin
        r_tens <= w_nxt_tens;
        r_ones <= w_nxt_ones;
        r_pm   <= w_nxt_pm;
      end
    end
  end

  assign hour_tens = r_tens;
  assign hour_ones = r_ones;
  assign pm        = MODE_12H ? r_pm : 1'b0;
  assign day_carry = r_day_carry;

endmodule

// File: tb/tb_cnt24_hour.sv
// 24h and 12h instances share inputs; both are checked against one
// hour-of-day reference counter (0..23) rendered into each display format.
module tb_cnt24_hour;

  logic clk = 1'b0;
  logic CLR_n, bit6, set_inc, isSetting;
  logic [3:0] t24, o24, t12, o12;
  logic pm24, pm12, dc24, dc12;

  int h;
  int n_pass = 0;
  int n_chk  = 0;

  always #5 clk = ~clk;

  cnt24_hour #(.MODE_12H(1'b0), .SYNC_STAGES(2)) dut24 (
    .clk(clk), .CLR_n(CLR_n), .bit6(bit6), .set_inc(set_inc), .isSetting(isSetting),
    .hour_tens(t24), .hour_ones(o24), .pm(pm24), .day_carry(dc24)
  );

  cnt24_hour #(.MODE_12H(1'b1), .SYNC_STAGES(2)) dut12 (
    .clk(clk), .CLR_n(CLR_n), .bit6(bit6), .set_inc(set_inc), .isSetting(isSetting),
    .hour_tens(t12), .hour_ones(o12), .pm(pm12), .day_carry(dc12)
  );

  task automatic cmp(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
  endtask

  task automatic chk(input string tag, input bit dc);
    int d12;
    d12 = (h % 12 == 0) ? 12 : h % 12;
    cmp({tag, " tens24"}, {4'd0, t24}, 8'(h / 10));
    cmp({tag, " ones24"}, {4'd0, o24}, 8'(h % 10));
    cmp({tag, " pm24"},   {7'd0, pm24}, 8'd0);
    cmp({tag, " dc24"},   {7'd0, dc24}, {7'd0, dc});
    cmp({tag, " tens12"}, {4'd0, t12}, 8'(d12 / 10));
    cmp({tag, " ones12"}, {4'd0, o12}, 8'(d12 % 10));
    cmp({tag, " pm12"},   {7'd0, pm12}, {7'd0, (h >= 12)});
    cmp({tag, " dc12"},   {7'd0, dc12}, {7'd0, dc});
  endtask

  // Raise inputs, optionally switch mode just before the edge cycle,
  // expect the update on the third rising edge, then hold and release.
  task automatic pulse(input bit b6, input bit si, input bit s0, input bit s1,
                       input int hold, input string tag);
    bit inc, wrap;
    @(negedge clk);
    isSetting = s0; bit6 = b6; set_inc = si;
    repeat (2) @(negedge clk);
    chk({tag, " pre"}, 1'b0);
    isSetting = s1;
    inc  = s1 ? si : b6;
    wrap = inc && (h == 23);
    if (inc) h = (h + 1) % 24;
    @(negedge clk);
    chk({tag, " upd"}, wrap && !s1);
    @(negedge clk);
    chk({tag, " post"}, 1'b0);
    repeat (hold) @(negedge clk);
    bit6 = 1'b0; set_inc = 1'b0;
    repeat (4) @(negedge clk);
    chk({tag, " rel"}, 1'b0);
  endtask

  task automatic set_to(input int target);
    while (h != target) pulse(1'b0, 1'b1, 1'b1, 1'b1, 1, "set");
  endtask

  initial begin
    h = 0;
    CLR_n = 1'b0; bit6 = 1'b0; set_inc = 1'b0; isSetting = 1'b0;
    #12;
    chk("reset", 1'b0);
    @(negedge clk);
    CLR_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle", 1'b0);

    // Random mix of sources and modes, including mode flips mid-sync.
    for (int i = 0; i < 30; i++) begin
      bit rb6, rsi;
      rb6 = 1'($urandom_range(0, 1));
      rsi = 1'($urandom_range(0, 1));
      if (!rb6 && !rsi) rb6 = 1'b1;
      pulse(rb6, rsi, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            int'($urandom_range(0, 20)), "rand");
    end

    set_to(22);
    pulse(1'b1, 1'b0, 1'b0, 1'b0, 2, "t1a");
    pulse(1'b1, 1'b0, 1'b0, 1'b0, 2, "t1b");

    pulse(1'b1, 1'b0, 1'b0, 1'b0, 1000, "t2");

    set_to(21);
    pulse(1'b1, 1'b0, 1'b1, 1'b1, 5, "t3ign");
    for (int i = 0; i < 5; i++) pulse(1'b0, 1'b1, 1'b1, 1'b1, 3, "t3");

    pulse(1'b1, 1'b1, 1'b0, 1'b0, 3, "t4");
    pulse(1'b1, 1'b0, 1'b0, 1'b1, 3, "modeflip");

    set_to(11);
    pulse(1'b1, 1'b0, 1'b0, 1'b0, 3, "t5am");
    pulse(1'b1, 1'b0, 1'b0, 1'b0, 3, "t5pm");
    set_to(23);
    pulse(1'b1, 1'b0, 1'b0, 1'b0, 3, "t5day");

    // Async clear while the carry level is high.
    set_to(5);
    @(negedge clk);
    isSetting = 1'b0; bit6 = 1'b1;
    repeat (3) @(negedge clk);
    h = 6;
    chk("t6inc", 1'b0);
    repeat (2) @(negedge clk);
    #2 CLR_n = 1'b0;
    h = 0;
    #1 chk("t6clr", 1'b0);
    @(negedge clk);
    CLR_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("t6hold", 1'b0);
    bit6 = 1'b0;
    repeat (4) @(negedge clk);
    pulse(1'b1, 1'b0, 1'b0, 1'b0, 2, "t6next");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
